axi_mem_responder: RTL

AXI4 slave-side memory model that answers the burst read and write traffic issued by the core's instruction-cache and data-cache AXI master ports. It accepts one read burst and one write burst concurrently on independent engines, serves 64-bit beats from an internal byte-addressable store with a configurable first-beat read latency, and returns write responses. It sits behind the arbitration point of the cache AXI ports and serves as the simulation main memory for the pipelined processor.

---
 rtl/axi_mem_pkg.sv | 25 ++
 rtl/axi_mem_store.sv | 32 +++
 rtl/axi_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI memory responder: response codes,
// read/write engine state encodings and an address alignment helper.
package axi_mem_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Every beat is a full 64-bit word, so the low three address bits are dropped.
  function automatic logic [63:0] align_addr(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/axi_mem_store.sv
// Byte-enabled 64-bit word array: one synchronous write port and one
// asynchronous read port. A read of the word being written in the same
// cycle returns the contents from before the write. Contents are never reset.
module axi_mem_store #(
  parameter int WORDS = 8192,
  parameter int IDX_W = 13
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [63:0]      wr_data,
  input  logic [7:0]       wr_strb,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [63:0]      rd_data
);

  logic [63:0] mem_r [WORDS];

  // Byte-lane write of the selected word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_strb[i]) begin
          mem_r[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model serving cache burst traffic. Independent read and
// write engines, 64-bit INCR beats, configurable first-beat read latency.
// Optional feature macro: AXI_MEM_RANGE_CHECK_EN -- beats addressing at or
// beyond MEM_BYTES return SLVERR (reads give zero data, writes are dropped)
// instead of wrapping modulo MEM_BYTES.
module axi_mem_responder import axi_mem_pkg::*; #(
  parameter int MEM_BYTES    = 65536,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [63:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp
);

  localparam int          WORDS     = MEM_BYTES / 8;
  localparam int          IDX_W     = $clog2(WORDS);
  localparam logic [3:0]  LAT_LOAD  = 4'(READ_LATENCY - 1);
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  // Read engine state and registered outputs
  rd_state_t   rd_state_r, rd_state_nx_s;
  logic [63:0] rd_addr_r, rd_addr_nx_s, rd_addr_s;
  logic [8:0]  rd_beats_r, rd_beats_nx_s;
  logic [3:0]  rd_cnt_r, rd_cnt_nx_s;
  logic        arready_r, arready_nx_s;
  logic        rvalid_r, rvalid_nx_s;
  logic [63:0] rdata_r, rdata_nx_s;
  logic [1:0]  rresp_r, rresp_nx_s;
  logic        rlast_r, rlast_nx_s;
  logic [63:0] store_rdata_s, rd_word_s;
  logic [1:0]  rd_word_resp_s;

  // Write engine state and registered outputs
  wr_state_t   wr_state_r, wr_state_nx_s;
  logic [63:0] wr_addr_r, wr_addr_nx_s;
  logic [8:0]  wr_beats_r, wr_beats_nx_s;
  logic        wr_err_r, wr_err_nx_s;
  logic        awready_r, awready_nx_s;
  logic        wready_r, wready_nx_s;
  logic        bvalid_r, bvalid_nx_s;
  logic [1:0]  bresp_r, bresp_nx_s;
  logic        wr_oob_s, wr_en_s, wr_beat_err_s;

  // Size/burst fields are fixed by construction; fold them into a sink.
  logic unused_s;
  assign unused_s = ^{s_axi_arsize, s_axi_arburst, s_axi_awsize, s_axi_awburst,
                      s_axi_araddr, s_axi_awaddr, rd_addr_r, wr_addr_r};

  axi_mem_store #(.WORDS(WORDS), .IDX_W(IDX_W)) u_store (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_idx  (wr_addr_r[IDX_W+2:3]),
    .wr_data (s_axi_wdata),
    .wr_strb (s_axi_wstrb),
    .rd_idx  (rd_addr_s[IDX_W+2:3]),
    .rd_data (store_rdata_s)
  );

  // Address of the word that becomes the next presented read beat.
  always_comb begin
    rd_addr_s = rd_addr_r;
    case (rd_state_r)
      R_IDLE:  rd_addr_s = align_addr(s_axi_araddr);
      R_WAIT:  rd_addr_s = rd_addr_r;
      R_BURST: rd_addr_s = rd_addr_r + 64'd8;
      default: rd_addr_s = rd_addr_r;
    endcase
  end

`ifdef AXI_MEM_RANGE_CHECK_EN
  assign rd_word_s      = (rd_addr_s >= MEM_LIMIT) ? 64'd0 : store_rdata_s;
  assign rd_word_resp_s = (rd_addr_s >= MEM_LIMIT) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign wr_oob_s       = (wr_addr_r >= MEM_LIMIT);
`else
  assign rd_word_s      = store_rdata_s;
  assign rd_word_resp_s = AXI_RESP_OKAY;
  assign wr_oob_s       = 1'b0;
`endif

  // Read engine next state: accept AR, wait out latency, stream beats.
  always_comb begin
    rd_state_nx_s = rd_state_r;
    rd_addr_nx_s  = rd_addr_r;
    rd_beats_nx_s = rd_beats_r;
    rd_cnt_nx_s   = rd_cnt_r;
    arready_nx_s  = arready_r;
    rvalid_nx_s   = rvalid_r;
    rdata_nx_s    = rdata_r;
    rresp_nx_s    = rresp_r;
    rlast_nx_s    = rlast_r;
    case (rd_state_r)
      R_IDLE: begin
        if (s_axi_arvalid && arready_r) begin
          rd_addr_nx_s  = rd_addr_s;
          rd_beats_nx_s = {1'b0, s_axi_arlen} + 9'd1;
          rd_cnt_nx_s   = LAT_LOAD;
          arready_nx_s  = 1'b0;
          if (LAT_LOAD == 4'd0) begin
            rd_state_nx_s = R_BURST;
            rvalid_nx_s   = 1'b1;
            rdata_nx_s    = rd_word_s;
            rresp_nx_s    = rd_word_resp_s;
            rlast_nx_s    = (s_axi_arlen == 8'd0);
          end else begin
            rd_state_nx_s = R_WAIT;
          end
        end else begin
          arready_nx_s = 1'b1;
        end
      end
      R_WAIT: begin
        if (rd_cnt_r <= 4'd1) begin
          rd_state_nx_s = R_BURST;
          rd_cnt_nx_s   = 4'd0;
          rvalid_nx_s   = 1'b1;
          rdata_nx_s    = rd_word_s;
          rresp_nx_s    = rd_word_resp_s;
          rlast_nx_s    = (rd_beats_r == 9'd1);
        end else begin
          rd_cnt_nx_s = rd_cnt_r - 4'd1;
        end
      end
      R_BURST: begin
        if (s_axi_rready) begin
          if (rd_beats_r == 9'd1) begin
            rd_state_nx_s = R_IDLE;
            rvalid_nx_s   = 1'b0;
            rlast_nx_s    = 1'b0;
            arready_nx_s  = 1'b1;
          end else begin
            rd_addr_nx_s  = rd_addr_s;
            rd_beats_nx_s = rd_beats_r - 9'd1;
            rdata_nx_s    = rd_word_s;
            rresp_nx_s    = rd_word_resp_s;
            rlast_nx_s    = (rd_beats_r == 9'd2);
          end
        end else begin
          rd_state_nx_s = R_BURST;
        end
      end
      default: begin
        rd_state_nx_s = R_IDLE;
        rvalid_nx_s   = 1'b0;
        rlast_nx_s    = 1'b0;
        arready_nx_s  = 1'b0;
      end
    endcase
  end

  // Read engine registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_r <= R_IDLE;
      rd_addr_r  <= 64'd0;
      rd_beats_r <= 9'd0;
      rd_cnt_r   <= 4'd0;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= 64'd0;
      rresp_r    <= AXI_RESP_OKAY;
      rlast_r    <= 1'b0;
    end else begin
      rd_state_r <= rd_state_nx_s;
      rd_addr_r  <= rd_addr_nx_s;
      rd_beats_r <= rd_beats_nx_s;
      rd_cnt_r   <= rd_cnt_nx_s;
      arready_r  <= arready_nx_s;
      rvalid_r   <= rvalid_nx_s;
      rdata_r    <= rdata_nx_s;
      rresp_r    <= rresp_nx_s;
      rlast_r    <= rlast_nx_s;
    end
  end

  // A beat is in error if wlast disagrees with the awlen count or it falls out of range.
  assign wr_beat_err_s = (s_axi_wlast != (wr_beats_r == 9'd1)) | wr_oob_s;
  assign wr_en_s = (wr_state_r == W_DATA) & s_axi_wvalid & wready_r & ~wr_oob_s & ~reset;

  // Write engine next state: accept AW, count W beats, return B.
  always_comb begin
    wr_state_nx_s = wr_state_r;
    wr_addr_nx_s  = wr_addr_r;
    wr_beats_nx_s = wr_beats_r;
    wr_err_nx_s   = wr_err_r;
    awready_nx_s  = awready_r;
    wready_nx_s   = wready_r;
    bvalid_nx_s   = bvalid_r;
    bresp_nx_s    = bresp_r;
    case (wr_state_r)
      W_IDLE: begin
        if (s_axi_awvalid && awready_r) begin
          wr_state_nx_s = W_DATA;
          wr_addr_nx_s  = align_addr(s_axi_awaddr);
          wr_beats_nx_s = {1'b0, s_axi_awlen} + 9'd1;
          wr_err_nx_s   = 1'b0;
          awready_nx_s  = 1'b0;
          wready_nx_s   = 1'b1;
        end else begin
          awready_nx_s = 1'b1;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_r) begin
          wr_addr_nx_s  = wr_addr_r + 64'd8;
          wr_beats_nx_s = wr_beats_r - 9'd1;
          wr_err_nx_s   = wr_err_r | wr_beat_err_s;
          if (wr_beats_r == 9'd1) begin
            wr_state_nx_s = W_RESP;
            wready_nx_s   = 1'b0;
            bvalid_nx_s   = 1'b1;
            bresp_nx_s    = (wr_err_r | wr_beat_err_s) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          end else begin
            wr_state_nx_s = W_DATA;
          end
        end else begin
          wr_state_nx_s = W_DATA;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wr_state_nx_s = W_IDLE;
          bvalid_nx_s   = 1'b0;
          bresp_nx_s    = AXI_RESP_OKAY;
          awready_nx_s  = 1'b1;
        end else begin
          wr_state_nx_s = W_RESP;
        end
      end
      default: begin
        wr_state_nx_s = W_IDLE;
        awready_nx_s  = 1'b0;
        wready_nx_s   = 1'b0;
        bvalid_nx_s   = 1'b0;
      end
    endcase
  end

  // Write engine registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_r <= W_IDLE;
      wr_addr_r  <= 64'd0;
      wr_beats_r <= 9'd0;
      wr_err_r   <= 1'b0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= AXI_RESP_OKAY;
    end else begin
      wr_state_r <= wr_state_nx_s;
      wr_addr_r  <= wr_addr_nx_s;
      wr_beats_r <= wr_beats_nx_s;
      wr_err_r   <= wr_err_nx_s;
      awready_r  <= awready_nx_s;
      wready_r   <= wready_nx_s;
      bvalid_r   <= bvalid_nx_s;
      bresp_r    <= bresp_nx_s;
    end
  end

  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rlast   = rlast_r;
  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;

endmodule
